// File: rtl/tmds_word_align_ctrl.sv
// TMDS word-alignment controller: finds control-token runs, bitslips until lock, resets the elastic buffer on persistent failure.
// Optional statistics outputs are enabled by defining TMDS_ALIGN_STATS_EN.
module tmds_word_align_ctrl #(
  parameter int SEARCH_WIN  = 2048,
  parameter int TOKEN_RUN   = 8,
  parameter int LOCK_HITS   = 4,
  parameter int LOSS_MISSES = 3,
  parameter int SLIP_WAIT   = 16,
  parameter int MAX_SLIPS   = 10,
  parameter int RST_LEN     = 8
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_en,
  input  logic [9:0]  I_data,
  output logic        O_bitslip,
  output logic        O_buf_rst,
  output logic        O_locked,
  output logic [2:0]  O_state
`ifdef TMDS_ALIGN_STATS_EN
  ,
  output logic [15:0] O_slip_total,
  output logic [7:0]  O_relock_cnt
`endif
);
  localparam int WIN_W = $clog2(SEARCH_WIN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SEARCH_WIN - 1);
  localparam logic [3:0] RUN_FULL  = 4'(TOKEN_RUN);
  localparam logic [3:0] RUN_PRE   = 4'(TOKEN_RUN - 1);
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_HITS - 1);
  localparam logic [3:0] MISS_LAST = 4'(LOSS_MISSES - 1);
  localparam logic [3:0] SLIP_LAST = 4'(MAX_SLIPS - 1);
  localparam logic [7:0] WAIT_LAST = 8'(SLIP_WAIT - 1);
  localparam logic [7:0] RST_LAST  = 8'(RST_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEARCH = 3'd1,
    ST_SLIP   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_BUFRST = 3'd4,
    ST_LOCKED = 3'd5
  } state_t;

  state_t           state;
  logic             match_r;
  logic [3:0]       run_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic             win_hit;
  logic [3:0]       hit_cnt;
  logic [3:0]       miss_cnt;
  logic [3:0]       slip_cnt;
  logic [7:0]       dly_cnt;

  logic tok_match;
  logic counting;
  logic run_evt;
  logic win_wrap;
  logic hit_now;

  assign tok_match = (I_data == 10'h354) || (I_data == 10'h0AB) ||
                     (I_data == 10'h154) || (I_data == 10'h2AB);
  assign counting  = (state == ST_SEARCH) || (state == ST_LOCKED);
  assign run_evt   = counting && match_r && (run_cnt == RUN_PRE);
  assign win_wrap  = (win_cnt == WIN_LAST);
  // A run completing on the wrap cycle still belongs to the window that is ending.
  assign hit_now   = win_hit || run_evt;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state     <= ST_IDLE;
      match_r   <= 1'b0;
      run_cnt   <= '0;
      win_cnt   <= '0;
      win_hit   <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      slip_cnt  <= '0;
      dly_cnt   <= '0;
      O_bitslip <= 1'b0;
      O_buf_rst <= 1'b0;
      O_locked  <= 1'b0;
    end else begin
      match_r   <= tok_match;
      O_bitslip <= 1'b0;
      if (counting) begin
        if (!match_r)
          run_cnt <= '0;
        else if (run_cnt != RUN_FULL)
          run_cnt <= run_cnt + 4'd1;
        win_cnt <= win_cnt + 1'b1;
        win_hit <= win_wrap ? 1'b0 : hit_now;
      end else begin
        run_cnt <= '0;
      end

      if (!I_en) begin
        state     <= ST_IDLE;
        O_buf_rst <= 1'b0;
        O_locked  <= 1'b0;
        run_cnt   <= '0;
        win_cnt   <= '0;
        win_hit   <= 1'b0;
        hit_cnt   <= '0;
        miss_cnt  <= '0;
        slip_cnt  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            win_cnt  <= '0;
            win_hit  <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            slip_cnt <= '0;
            state    <= ST_SEARCH;
          end
          ST_SEARCH: begin
            if (win_wrap) begin
              if (hit_now) begin
                hit_cnt <= hit_cnt + 4'd1;
                if (hit_cnt == LOCK_LAST) begin
                  state    <= ST_LOCKED;
                  O_locked <= 1'b1;
                  slip_cnt <= '0;
                  miss_cnt <= '0;
                end
              end else begin
                hit_cnt   <= '0;
                state     <= ST_SLIP;
                O_bitslip <= 1'b1;
              end
            end
          end
          ST_SLIP: begin
            slip_cnt <= slip_cnt + 4'd1;
            dly_cnt  <= '0;
            if (slip_cnt == SLIP_LAST) begin
              state     <= ST_BUFRST;
              O_buf_rst <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (dly_cnt == WAIT_LAST) begin
              state   <= ST_SEARCH;
              win_cnt <= '0;
              win_hit <= 1'b0;
            end else begin
              dly_cnt <= dly_cnt + 8'd1;
            end
          end
          ST_BUFRST: begin
            // After the reset pulse the settle period reuses the WAIT timer.
            if (dly_cnt == RST_LAST) begin
              O_buf_rst <= 1'b0;
              slip_cnt  <= '0;
              dly_cnt   <= '0;
              state     <= ST_WAIT;
            end else begin
              dly_cnt <= dly_cnt + 8'd1;
            end
          end
          ST_LOCKED: begin
            if (win_wrap) begin
              if (hit_now) begin
                miss_cnt <= '0;
              end else if (miss_cnt == MISS_LAST) begin
                state    <= ST_SEARCH;
                O_locked <= 1'b0;
                hit_cnt  <= '0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + 4'd1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign O_state = state;

`ifdef TMDS_ALIGN_STATS_EN
  logic locked_q;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      locked_q     <= 1'b0;
      O_slip_total <= '0;
      O_relock_cnt <= '0;
    end else begin
      locked_q <= O_locked;
      if (O_bitslip && (O_slip_total != 16'hFFFF))
        O_slip_total <= O_slip_total + 16'd1;
      if (locked_q && !O_locked && (state == ST_SEARCH) && (O_relock_cnt != 8'hFF))
        O_relock_cnt <= O_relock_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tmds_word_align_ctrl.sv
// Bench for tmds_word_align_ctrl: output events (slip, buffer reset, lock edges) are predicted with cycle stamps
// into a queue as stimulus is applied and compared as the DUT produces them.
module tb_tmds_word_align_ctrl;
  localparam int W  = 128;
  localparam int TR = 8;
  localparam int LH = 4;
  localparam int LM = 3;
  localparam int SW = 16;
  localparam int MS = 10;
  localparam int RL = 8;
  localparam int P  = W + SW + 1;

  localparam int K_SLIP     = 1;
  localparam int K_BUF_ON   = 2;
  localparam int K_BUF_OFF  = 3;
  localparam int K_LOCK_ON  = 4;
  localparam int K_LOCK_OFF = 5;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [9:0] data = 10'h1F0;
  logic       bitslip, buf_rst, locked;
  logic [2:0] state;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_bad = 0;
  logic [31:0] exp_q[$];
  logic       prev_buf = 1'b0;
  logic       prev_lock = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef TMDS_ALIGN_STATS_EN
  logic [15:0] slip_total;
  logic [7:0]  relock_cnt;
  int          slips_seen = 0;
`endif

  tmds_word_align_ctrl #(
    .SEARCH_WIN(W), .TOKEN_RUN(TR), .LOCK_HITS(LH), .LOSS_MISSES(LM),
    .SLIP_WAIT(SW), .MAX_SLIPS(MS), .RST_LEN(RL)
  ) dut (
    .I_clk(clk),
    .I_rst(rst),
    .I_en(en),
    .I_data(data),
    .O_bitslip(bitslip),
    .O_buf_rst(buf_rst),
    .O_locked(locked),
    .O_state(state)
`ifdef TMDS_ALIGN_STATS_EN
    ,
    .O_slip_total(slip_total),
    .O_relock_cnt(relock_cnt)
`endif
  );

  // scoreboard
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ev(input int kind, input int st, input int c);
    return {4'(kind), 4'(st), 24'(c)};
  endfunction

  task automatic take(input logic [31:0] got);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", got, 32'h0);
    end else begin
      e = exp_q.pop_front();
      check("event", got, e);
    end
  endtask

  always @(negedge clk) begin
    if (bitslip) take(ev(K_SLIP, int'(state), cyc));
    if (buf_rst && !prev_buf) take(ev(K_BUF_ON, int'(state), cyc));
    if (!buf_rst && prev_buf) take(ev(K_BUF_OFF, 0, cyc));
    if (locked && !prev_lock) take(ev(K_LOCK_ON, int'(state), cyc));
    if (!locked && prev_lock) take(ev(K_LOCK_OFF, int'(state), cyc));
    if (bitslip || buf_rst) check("slip_bufrst_exclusive", 32'(bitslip & buf_rst), 32'd0);
    prev_buf  <= buf_rst;
    prev_lock <= locked;
`ifdef TMDS_ALIGN_STATS_EN
    if (rst) slips_seen <= 0;
    else if (bitslip) slips_seen <= slips_seen + 1;
`endif
  end

  // driver
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_token(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  function automatic logic [9:0] token();
    logic [9:0] toks [4];
    toks = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    return toks[$urandom_range(0, 3)];
  endfunction

  function automatic logic [9:0] filler();
    logic [9:0] w;
    do w = 10'($urandom_range(0, 1023)); while (is_token(w));
    return w;
  endfunction

  // mode 0: constant 1F0; 1: 12-word runs every 60 cycles until lim; 2: 7-word runs every 40; 3: tokens in [base, lim]
  function automatic logic [9:0] word_for(input int mode, input int c, input int base, input int lim);
    int rel;
    rel = c - base;
    case (mode)
      1: return ((c < lim) && (rel % 60 < 12)) ? token() : filler();
      2: return (rel % 40 < 7) ? token() : filler();
      3: return ((c >= base) && (c <= lim)) ? token() : filler();
      default: return 10'h1F0;
    endcase
  endfunction

  task automatic run_until(input int stop, input int mode, input int base, input int lim);
    while (cyc < stop) begin
      data = word_for(mode, cyc, base, lim);
      tick();
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    en   = 1'b0;
    data = 10'h1F0;
    repeat (3) tick();
    check("rst_bitslip", 32'(bitslip), 32'd0);
    check("rst_buf_rst", 32'(buf_rst), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    rst = 1'b0;
    tick();
  endtask

  task automatic check_drained(input string tag);
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, a, b, z, d;
    tick();

    // Aligned stream locks after LH windows, then loses lock after LM empty windows.
    do_reset();
    en = 1'b1;
    s  = cyc + 1;
    exp_q.push_back(ev(K_LOCK_ON, 5, s + 4 * W));
    exp_q.push_back(ev(K_LOCK_OFF, 1, s + 7 * W));
    exp_q.push_back(ev(K_SLIP, 2, s + 8 * W));
    run_until(s + 4 * W, 1, s - 1, s + 4 * W - 20);
    check("lock_state", 32'(state), 32'd5);
    check("lock_out", 32'(locked), 32'd1);
    run_until(s + 7 * W, 1, s - 1, s + 4 * W - 20);
    check("loss_state", 32'(state), 32'd1);
    check("loss_no_slip", 32'(bitslip), 32'd0);
    run_until(s + 8 * W + 3, 1, s - 1, s + 4 * W - 20);
    check_drained("aligned_pending");
`ifdef TMDS_ALIGN_STATS_EN
    check("relock_cnt", 32'(relock_cnt), 32'd1);
    check("slip_total_a", 32'(slip_total), 32'(slips_seen));
`endif

    // No tokens: slips at a fixed cadence, buffer reset after MS slips, then disable mid buffer reset.
    do_reset();
    en   = 1'b1;
    data = 10'h1F0;
    s    = cyc + 1;
    for (int k = 0; k < MS; k++) exp_q.push_back(ev(K_SLIP, 2, s + W + k * P));
    a = s + W + (MS - 1) * P;
    exp_q.push_back(ev(K_BUF_ON, 4, a + 1));
    exp_q.push_back(ev(K_BUF_OFF, 0, a + 1 + RL));
    b = a + 1 + RL + SW + W;
    for (int k = 0; k < MS; k++) exp_q.push_back(ev(K_SLIP, 2, b + k * P));
    z = b + (MS - 1) * P;
    d = z + 4;
    exp_q.push_back(ev(K_BUF_ON, 4, z + 1));
    exp_q.push_back(ev(K_BUF_OFF, 0, d + 1));
    run_until(d, 0, 0, 0);
    check("in_bufrst", 32'(state), 32'd4);
`ifdef TMDS_ALIGN_STATS_EN
    check("slip_total_b", 32'(slip_total), 32'(slips_seen));
`endif
    en = 1'b0;
    tick();
    check("dis_state", 32'(state), 32'd0);
    check("dis_buf_rst", 32'(buf_rst), 32'd0);
    check("dis_bitslip", 32'(bitslip), 32'd0);
    repeat (3) tick();
    check_drained("notoken_pending");

    // Short runs never make a hit.
    do_reset();
    en = 1'b1;
    s  = cyc + 1;
    for (int k = 0; k < 4; k++) exp_q.push_back(ev(K_SLIP, 2, s + W + k * P));
    run_until(s + W + 3 * P + 5, 2, s - 1, 0);
    check("short_locked", 32'(locked), 32'd0);
    check_drained("short_pending");

    // Run completing exactly on the wrap cycle counts as a hit; one cycle later it does not.
    for (int off = 0; off < 2; off++) begin
      do_reset();
      en = 1'b1;
      s  = cyc + 1;
      if (off == 0) begin
        exp_q.push_back(ev(K_SLIP, 2, s + 2 * W));
      end else begin
        exp_q.push_back(ev(K_SLIP, 2, s + W));
        exp_q.push_back(ev(K_SLIP, 2, s + W + P));
      end
      run_until(s + W, 3, s + W - 9 + off, s + W - 2 + off);
      check("wrap_state", 32'(state), (off == 0) ? 32'd1 : 32'd2);
      run_until((off == 0) ? s + 2 * W + 2 : s + W + P + 2, 3, s + W - 9 + off, s + W - 2 + off);
      check_drained("boundary_pending");
    end

    // Reset mid-WAIT overrides enable; search restarts afterwards.
    do_reset();
    en = 1'b1;
    s  = cyc + 1;
    exp_q.push_back(ev(K_SLIP, 2, s + W));
    run_until(s + W + 5, 0, 0, 0);
    check("in_wait", 32'(state), 32'd3);
    rst = 1'b1;
    tick();
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_bitslip", 32'(bitslip), 32'd0);
    check("mid_rst_buf_rst", 32'(buf_rst), 32'd0);
    check("mid_rst_locked", 32'(locked), 32'd0);
    rst = 1'b0;
    s   = cyc + 1;
    exp_q.push_back(ev(K_SLIP, 2, s + W));
    run_until(s + W + 2, 0, 0, 0);
    check_drained("rst_pending");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
